// File: rtl/gf_ops_pkg.sv
// Shared opcodes, RAM-mux selects and sequencer state type for the GF(2^m) op units.
package gf_ops_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_MUL = 4'd1;
    localparam logic [3:0] OP_SQR = 4'd2;
    localparam logic [3:0] OP_ADD = 4'd3;

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_MUL  = 3'd1;
    localparam logic [2:0] SEL_SQR  = 3'd2;
    localparam logic [2:0] SEL_ADD  = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } seq_state_t;

    function automatic logic op_is_valid(input logic [3:0] op);
        return (op == OP_MUL) || (op == OP_SQR) || (op == OP_ADD);
    endfunction

endpackage

// File: rtl/op_fifo.sv
// Synchronous instruction FIFO, first-word fall-through, registered full/empty/count.
module op_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count_nx;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        count_nx = count;
        case ({do_push, do_pop})
            2'b10:   count_nx = count + (PTR_W+1)'(1);
            2'b01:   count_nx = count - (PTR_W+1)'(1);
            default: ;
        endcase
    end

    // Flags come from the next count so they are flops yet never lag a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nx;
            full  <= (count_nx == FULL_CNT);
            empty <= (count_nx == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/gf_op_sequencer.sv
// Issues queued field-op instructions one at a time, routes the shared RAM to the
// active unit and waits (with timeout) for that unit's completion pulse.
module gf_op_sequencer
    import gf_ops_pkg::*;
#(
    parameter int ADDR    = 3,
    parameter int LEN_W   = 10,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [3:0]       instr_op,
    input  logic [ADDR-1:0]  instr_addr,
    input  logic [LEN_W-1:0] instr_len,
    output logic [3:0]       command,
    output logic [ADDR-1:0]  start_addr,
    output logic [LEN_W-1:0] data_len,
    output logic [2:0]       select_line,
    input  logic             mul_irq,
    input  logic             sqr_irq,
    input  logic             add_irq,
    output logic             busy,
    output logic             done,
    output logic             err_op,
    output logic             err_timeout
);

    localparam int FW    = 4 + ADDR + LEN_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;
    logic [FW-1:0]    wdata;
    logic [FW-1:0]    rdata;
    logic [3:0]       head_op;
    logic [ADDR-1:0]  head_addr;
    logic [LEN_W-1:0] head_len;

    seq_state_t       state;
    seq_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic [3:0]       cmd_nx;
    logic [2:0]       sel_nx;
    logic [ADDR-1:0]  addr_nx;
    logic [LEN_W-1:0] len_nx;
    logic             done_nx;
    logic             err_op_nx;
    logic             err_to_nx;
    logic             irq_hit;

    assign push        = instr_valid && !full;
    assign instr_ready = !full;
    assign wdata       = {instr_op, instr_addr, instr_len};
    assign head_op     = rdata[FW-1 -: 4];
    assign head_addr   = rdata[LEN_W +: ADDR];
    assign head_len    = rdata[LEN_W-1:0];
    assign busy        = (state != ST_IDLE) || (level != '0);

    op_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (level)
    );

    always_comb begin
        irq_hit = 1'b0;
        case (select_line)
            SEL_MUL: irq_hit = mul_irq;
            SEL_SQR: irq_hit = sqr_irq;
            SEL_ADD: irq_hit = add_irq;
            default: ;
        endcase
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        cmd_nx    = OP_NOP;
        sel_nx    = select_line;
        addr_nx   = start_addr;
        len_nx    = data_len;
        done_nx   = 1'b0;
        err_op_nx = 1'b0;
        err_to_nx = 1'b0;
        pop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (op_is_valid(head_op)) begin
                        cmd_nx   = head_op;
                        sel_nx   = head_op[2:0];
                        addr_nx  = head_addr;
                        len_nx   = head_len;
                        state_nx = ST_ISSUE;
                    end else begin
                        err_op_nx = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_nx   = '0;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion on the final counted cycle still wins over the timeout.
                if (irq_hit) begin
                    done_nx  = 1'b1;
                    state_nx = ST_DONE;
                end else if (cnt == CNT_W'(TIMEOUT)) begin
                    err_to_nx = 1'b1;
                    sel_nx    = SEL_NONE;
                    state_nx  = ST_IDLE;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            ST_DONE: begin
                sel_nx   = SEL_NONE;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            command     <= '0;
            select_line <= '0;
            start_addr  <= '0;
            data_len    <= '0;
            done        <= 1'b0;
            err_op      <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            cnt         <= cnt_nx;
            command     <= cmd_nx;
            select_line <= sel_nx;
            start_addr  <= addr_nx;
            data_len    <= len_nx;
            done        <= done_nx;
            err_op      <= err_op_nx;
            err_timeout <= err_to_nx;
        end
    end

endmodule
